neuron_ring_sched: RTL

Time-multiplexing scheduler that shares one neuron update datapath (stimulus current in, membrane state and spike out) across `N_NEURONS` virtual neurons wired in a unidirectional ring. It holds per-neuron state and stimulus, sequences one update round per neuron over a valid/ready + done handshake, injects synaptic current from the upstream neuron's previous spike, and publishes the spike vector. It sits between the top-level I/O wrapper and the single neuron instance.

---
 rtl/neuron_ring_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/neuron_ring_sched.sv
// neuron_ring_sched
//   Time-multiplexes one neuron update datapath across N_NEURONS virtual
//   neurons wired in a unidirectional ring (neuron i is driven by i-1, and
//   neuron 0 by N-1). Each round issues every neuron once, in index order,
//   over a valid/ready request plus a single-cycle done strobe. The resulting
//   spikes are published together at the end of the round.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               allows a new round to start from IDLE
//   cfg_we/addr/data  stimulus register write port, usable at any time
//   mon_sel/mon_state registered read of one neuron's membrane state
//   upd_valid/ready   request handshake towards the datapath
//   upd_state/current request payload, held stable while upd_valid is high
//   upd_done          single-cycle result strobe carrying the fields below
//   upd_state_nx      updated membrane state
//   upd_spike         spike flag
//   spike_vec         spikes from the last completed round
//   round_done        one-cycle pulse when spike_vec is refreshed
//   busy              high whenever a round is in progress
//   err               sticky datapath-timeout flag, cleared only by reset
module neuron_ring_sched #(
  parameter int             N_NEURONS = 4,
  parameter int             W         = 8,
  parameter logic [W-1:0]   W_SYN     = 8'd40,
  parameter int             TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
  input  logic [W-1:0]                  cfg_data,
  input  logic [$clog2(N_NEURONS)-1:0]  mon_sel,
  output logic                          upd_valid,
  input  logic                          upd_ready,
  output logic [W-1:0]                  upd_state,
  output logic [W-1:0]                  upd_current,
  input  logic                          upd_done,
  input  logic [W-1:0]                  upd_state_nx,
  input  logic                          upd_spike,
  output logic [N_NEURONS-1:0]          spike_vec,
  output logic [W-1:0]                  mon_state,
  output logic                          round_done,
  output logic                          busy,
  output logic                          err
);

  localparam int AW = $clog2(N_NEURONS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_END} fsm_t;

  fsm_t                 state;
  logic [AW-1:0]        idx;
  logic [CW-1:0]        wait_cnt;
  logic [W-1:0]         state_mem [N_NEURONS];
  logic [W-1:0]         stim_mem  [N_NEURONS];
  logic [N_NEURONS-1:0] spike_next;
  logic [W-1:0]         wb_state;
  logic                 wb_spike;

  // Payload for the neuron about to be issued: index 0 when leaving IDLE,
  // otherwise the successor of the neuron being written back. The request is
  // latched on entry to ISSUE, so it stays stable under backpressure and a
  // stimulus write landing on the handshake edge cannot alter it.
  logic [AW-1:0]        issue_idx;
  logic [AW-1:0]        up_idx;
  logic [W:0]           syn_sum;
  logic [W-1:0]         issue_current;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    issue_idx     = (state == S_IDLE) ? '0 : idx + 1'b1;
    up_idx        = issue_idx - 1'b1;  // wraps to N-1 for neuron 0
    syn_sum       = {1'b0, stim_mem[issue_idx]}
                  + {1'b0, (spike_vec[up_idx] ? W_SYN : {W{1'b0}})};
    issue_current = syn_sum[W] ? {W{1'b1}} : syn_sum[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      wb_state    <= '0;
      wb_spike    <= 1'b0;
      spike_next  <= '0;
      spike_vec   <= '0;
      upd_valid   <= 1'b0;
      upd_state   <= '0;
      upd_current <= '0;
      mon_state   <= '0;
      round_done  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      // NOTE: these arrays are small flop banks, not RAM macros, and a known
      // post-reset neuron state is part of the block's behaviour, so they are
      // cleared here like any other register.
      for (int i = 0; i < N_NEURONS; i++) begin
        state_mem[i] <= '0;
        stim_mem[i]  <= '0;
      end
    end else begin
      round_done <= 1'b0;
      mon_state  <= state_mem[mon_sel];
      if (cfg_we) stim_mem[cfg_addr] <= cfg_data;

      case (state)
        S_IDLE: begin
          if (ena) begin
            idx         <= '0;
            upd_valid   <= 1'b1;
            upd_state   <= state_mem[issue_idx];
            upd_current <= issue_current;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end

        // A done on the last permitted WAIT cycle takes priority over the
        // timeout. On timeout the neuron keeps its state and does not spike.
        S_WAIT: begin
          if (upd_done) begin
            wb_state <= upd_state_nx;
            wb_spike <= upd_spike;
            state    <= S_WB;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            wb_state <= upd_state;
            wb_spike <= 1'b0;
            err      <= 1'b1;
            state    <= S_WB;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WB: begin
          state_mem[idx]  <= wb_state;
          spike_next[idx] <= wb_spike;
          if (idx == AW'(N_NEURONS - 1)) begin
            state <= S_END;
          end else begin
            idx         <= idx + 1'b1;
            upd_valid   <= 1'b1;
            upd_state   <= state_mem[issue_idx];
            upd_current <= issue_current;
            state       <= S_ISSUE;
          end
        end

        // Spikes become visible to the ring only here, so neurons within a
        // round never see each other's fresh results.
        S_END: begin
          spike_vec  <= spike_next;
          round_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
